// File: rtl/ram_dp_clr.sv
// ram_dp_clr: DEPTH x DATA_W RAM, port A read/write with byte enables, port B read-only, zero-fill clear engine.
// Latency: both read ports registered (1 cycle); clear takes DEPTH cycles after reset or clr.
// Backpressure: none, requests are dropped while busy. RAM_DP_WRITE_THROUGH_EN selects write-through on A/B collision.
module ram_dp_clr #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    output logic                busy,
    input  logic                a_cen,
    input  logic                a_wen,
    input  logic [DATA_W/8-1:0] a_be,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W-1:0]   a_din,
    output logic [DATA_W-1:0]   a_dout,
    input  logic                b_cen,
    input  logic [ADDR_W-1:0]   b_addr,
    output logic [DATA_W-1:0]   b_dout
);
    localparam int                NB      = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   cnt, cnt_nxt;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                a_ok, b_ok, idle_go, a_wr, we;
    logic [DATA_W-1:0]   a_old, b_old, a_merged, b_rd, wdat;
    logic [ADDR_W-1:0]   waddr;

    assign a_ok    = {1'b0, a_addr} < DEPTH_L;
    assign b_ok    = {1'b0, b_addr} < DEPTH_L;
    assign a_old   = a_ok ? mem[a_addr] : '0;
    assign b_old   = b_ok ? mem[b_addr] : '0;
    // The clr cycle itself performs no port access.
    assign idle_go = (state == IDLE) && !clr;
    assign a_wr    = idle_go && a_cen && a_wen && a_ok;
    assign busy    = (state == CLEAR);

    always_comb begin
        a_merged = a_old;
        for (int i = 0; i < NB; i++) begin
            if (a_be[i]) a_merged[8*i +: 8] = a_din[8*i +: 8];
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        we        = 1'b0;
        waddr     = a_addr;
        wdat      = a_merged;
        case (state)
            CLEAR: begin
                we      = 1'b1;
                waddr   = cnt;
                wdat    = '0;
                cnt_nxt = cnt + 1'b1;
                if (cnt == LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                we = a_wr;
                if (clr) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdat;
    end

`ifdef RAM_DP_WRITE_THROUGH_EN
    assign b_rd = (a_wr && (a_addr == b_addr)) ? a_merged : b_old;
`else
    assign b_rd = b_old;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_dout <= '0;
            b_dout <= '0;
        end else begin
            a_dout <= (idle_go && a_cen && !a_wen) ? a_old : '0;
            b_dout <= (idle_go && b_cen) ? b_rd : '0;
        end
    end
endmodule

// File: tb/tb_ram_dp_clr.sv
// Scoreboard bench for ram_dp_clr: the driver queues expected outputs per cycle,
// a monitor pops and compares them one cycle later, just after the clock edge.
module tb_ram_dp_clr;
    logic        clk = 1'b0;
    logic        reset, clr, a_cen, a_wen, b_cen, busy;
    logic [3:0]  a_be;
    logic [5:0]  a_addr, b_addr;
    logic [31:0] a_din, a_dout, b_dout;

    int          n_chk = 0;
    int          n_bad = 0;
    int          cyc_n = 0;
    int          tag   = 0;
    int          q_due[$];
    int          q_kind[$];
    int          q_tag[$];
    logic [31:0] q_val[$];

`ifdef RAM_DP_WRITE_THROUGH_EN
    localparam logic [31:0] COLL_EXP = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] COLL_EXP = 32'h1234_5678;
`endif

    ram_dp_clr #(.DATA_W(32), .ADDR_W(6), .DEPTH(64)) dut (
        .clk(clk), .reset(reset), .clr(clr), .busy(busy),
        .a_cen(a_cen), .a_wen(a_wen), .a_be(a_be), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout),
        .b_cen(b_cen), .b_addr(b_addr), .b_dout(b_dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %08h want %08h", nm, act, exp_v);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc_n++;
            #1;
            while (q_due.size() > 0 && q_due[0] <= cyc_n) begin
                int d, k, t;
                logic [31:0] v, act;
                d   = q_due.pop_front();
                k   = q_kind.pop_front();
                t   = q_tag.pop_front();
                v   = q_val.pop_front();
                act = (k == 0) ? a_dout : (k == 1) ? b_dout : {31'b0, busy};
                if (d != cyc_n) begin
                    n_bad++;
                    $display("FAIL sched_t%0d: due cycle %0d seen at %0d", t, d, cyc_n);
                end else begin
                    chk($sformatf("t%0d_%s_c%0d", t, (k == 0) ? "a_dout" : (k == 1) ? "b_dout" : "busy", d), act, v);
                end
            end
        end
    end

    task automatic drv(input logic ac, input logic aw, input logic [3:0] be, input logic [5:0] aa,
                       input logic [31:0] ad, input logic bc, input logic [5:0] ba, input logic cl);
        a_cen = ac; a_wen = aw; a_be = be; a_addr = aa; a_din = ad;
        b_cen = bc; b_addr = ba; clr = cl;
    endtask

    task automatic expect_nxt(input int k, input logic [31:0] v);
        q_due.push_back(cyc_n + 1);
        q_kind.push_back(k);
        q_tag.push_back(tag);
        q_val.push_back(v);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic nop();
        drv(1'b0, 1'b0, 4'h0, 6'd0, 32'h0, 1'b0, 6'd0, 1'b0);
    endtask

    task automatic wr(input logic [5:0] aa, input logic [31:0] ad, input logic [3:0] be);
        drv(1'b1, 1'b1, be, aa, ad, 1'b0, 6'd0, 1'b0);
        expect_nxt(0, 32'h0);
        tick();
    endtask

    task automatic rd_a(input logic [5:0] aa, input logic [31:0] exp_v);
        drv(1'b1, 1'b0, 4'h0, aa, 32'h0, 1'b0, 6'd0, 1'b0);
        expect_nxt(0, exp_v);
        tick();
    endtask

    task automatic rd_b(input logic [5:0] ba, input logic [31:0] exp_v);
        drv(1'b0, 1'b0, 4'h0, 6'd0, 32'h0, 1'b1, ba, 1'b0);
        expect_nxt(1, exp_v);
        tick();
    endtask

    // Iteration i expects busy after the i-th following edge: high through 63, low at 64.
    task automatic busy_run(input int last_i, input int clr_a, input int clr_b, input int wr_at);
        for (int i = 1; i <= last_i; i++) begin
            nop();
            if (i == clr_a || i == clr_b) clr = 1'b1;
            if (i == wr_at) begin
                drv(1'b1, 1'b1, 4'hF, 6'd2, 32'h0000_CAFE, 1'b1, 6'd2, 1'b0);
                expect_nxt(0, 32'h0);
                expect_nxt(1, 32'h0);
            end
            expect_nxt(2, (i < 64) ? 32'd1 : 32'd0);
            tick();
        end
    endtask

    task automatic hold_reset();
        for (int i = 0; i < 2; i++) begin
            nop();
            expect_nxt(0, 32'h0);
            expect_nxt(1, 32'h0);
            expect_nxt(2, 32'd1);
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: no finish by time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        nop();
        tick();
        tag = 0; hold_reset();
        tag = 1; reset = 1'b0; busy_run(64, 0, 0, 0);
        tag = 2;
        for (int i = 0; i < 64; i++) rd_b(6'(i), 32'h0);

        tag = 3;
        wr(6'd5, 32'hAABB_CCDD, 4'b1111);
        wr(6'd5, 32'h1122_3344, 4'b0101);
        rd_a(6'd5, 32'hAA22_CC44);
        wr(6'd5, 32'h0000_0000, 4'b0000);
        rd_a(6'd5, 32'hAA22_CC44);
        wr(6'd63, 32'h5A5A_5A5A, 4'b1111);
        rd_b(6'd63, 32'h5A5A_5A5A);

        tag = 4;
        wr(6'd9, 32'h1234_5678, 4'b1111);
        drv(1'b1, 1'b1, 4'b1111, 6'd9, 32'hFFFF_FFFF, 1'b1, 6'd9, 1'b0);
        expect_nxt(0, 32'h0);
        expect_nxt(1, COLL_EXP);
        tick();
        rd_b(6'd9, 32'hFFFF_FFFF);
        rd_a(6'd9, 32'hFFFF_FFFF);

        tag = 5;
        wr(6'd0, 32'hDEAD_BEEF, 4'b1111);
        drv(1'b1, 1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 6'd0, 1'b0);
        expect_nxt(0, 32'hDEAD_BEEF);
        expect_nxt(1, 32'hDEAD_BEEF);
        tick();
        nop();
        expect_nxt(0, 32'h0);
        expect_nxt(1, 32'h0);
        tick();
        rd_b(6'd0, 32'hDEAD_BEEF);

        tag = 6;
        for (int i = 0; i < 4; i++) wr(6'(i), 32'h0101_0101 * (i + 1), 4'b1111);
        rd_a(6'd1, 32'h0202_0202);
        drv(1'b1, 1'b0, 4'h0, 6'd1, 32'h0, 1'b1, 6'd1, 1'b1);
        expect_nxt(0, 32'h0);
        expect_nxt(1, 32'h0);
        expect_nxt(2, 32'd1);
        tick();
        busy_run(64, 0, 0, 10);
        for (int i = 0; i < 4; i++) rd_a(6'(i), 32'h0);
        rd_b(6'd2, 32'h0);

        tag = 7;
        wr(6'd7, 32'h7777_7777, 4'b1111);
        drv(1'b1, 1'b0, 4'h0, 6'd7, 32'h0, 1'b1, 6'd7, 1'b0);
        expect_nxt(0, 32'h7777_7777);
        expect_nxt(1, 32'h7777_7777);
        tick();
        reset = 1'b1;
        #1;
        chk("async_rst_a_dout", a_dout, 32'h0);
        chk("async_rst_b_dout", b_dout, 32'h0);
        chk("async_rst_busy", {31'b0, busy}, 32'd1);
        tick();
        hold_reset();
        reset = 1'b0;
        busy_run(30, 0, 0, 0);

        tag = 8;
        reset = 1'b1;
        #1;
        chk("midclr_rst_busy", {31'b0, busy}, 32'd1);
        chk("midclr_rst_a_dout", a_dout, 32'h0);
        tick();
        hold_reset();
        reset = 1'b0;
        busy_run(64, 10, 40, 0);
        rd_a(6'd7, 32'h0);
        rd_b(6'd9, 32'h0);
        rd_b(6'd63, 32'h0);

        nop();
        tick();
        tick();
        tick();
        if (q_due.size() != 0) begin
            n_bad++;
            $display("FAIL leftover: %0d expectations unchecked, want 0", q_due.size());
        end
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/ram_dp_clr.md
Name: ram_dp_clr

Overview:
- Parametrised successor to the team's 64x32 single-port synchronous RAM.
- Adds a second read-only port, per-byte write enables, and a hardware clear engine that zero-fills the array after reset or on request.
- Serves as a data/stack memory in the Top datapath where the CPU core writes and reads through port A while a display/debug path reads through port B.
- Both read ports are synchronous: data is registered, with 1-cycle latency.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- ADDR_W, 6, address width.
- DEPTH, 64, number of words; 1 <= DEPTH <= 2**ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- clr  in  1  clear request; sampled only in IDLE.
- busy  out  1  high while the clear engine owns the array.
- a_cen  in  1  port A chip enable.
- a_wen  in  1  port A write enable; qualified by a_cen.
- a_be  in  DATA_W/8  port A byte enables; bit i covers din[8i+7:8i].
- a_addr  in  ADDR_W  port A address.
- a_din  in  DATA_W  port A write data.
- a_dout  out  DATA_W  port A registered read data.
- b_cen  in  1  port B read enable.
- b_addr  in  ADDR_W  port B address.
- b_dout  out  DATA_W  port B registered read data.

Behaviour:
- Reset (async assert):
  - state=CLEAR, clear counter=0, busy=1, a_dout=0, b_dout=0.
  - Array contents are not reset directly; the clear engine zeroes them after reset deasserts.
- States:
  - CLEAR: each clk writes 0 to mem[cnt] and increments cnt. When cnt==DEPTH-1 that word is written, then the next state is IDLE and busy drops to 0 on the same edge. Total time in CLEAR is exactly DEPTH cycles.
  - IDLE: normal access. clr=1 moves to CLEAR on the next edge with cnt=0 and busy=1; no port access is performed in that cycle.
- clr asserted while in CLEAR is ignored; the clear does not restart.
- While busy=1:
  - Port A and port B requests are ignored.
  - a_dout and b_dout are forced to 0 on each edge.
- Port A, IDLE:
  - a_cen=1, a_wen=1: bytes with a_be[i]=1 take a_din; the other bytes keep their old value. a_dout<=0 next edge. a_be=0 writes nothing.
  - a_cen=1, a_wen=0: a_dout<=mem[a_addr] next edge.
  - a_cen=0: a_dout<=0 next edge.
- Port B, IDLE:
  - b_cen=1: b_dout<=mem[b_addr] next edge.
  - b_cen=0: b_dout<=0.
- Out-of-range address (addr>=DEPTH):
  - Writes are dropped; the array is unchanged.
  - Reads return 0.
- Collision: A write and B read to the same address in the same cycle gives read-first; b_dout gets the pre-write word. Unless WRITE_THROUGH_EN is defined (see below).
- Reset asserted mid-clear or mid-access: async return to the reset values above, and the clear restarts from address 0.

Optional Feature:
- Macro RAM_DP_WRITE_THROUGH_EN.
- Defined: on a same-address A-write/B-read collision, b_dout gets the merged post-write word (new bytes where a_be=1, old bytes elsewhere). This is a write-through bypass.
- Not defined: read-first; b_dout gets the old word.
- Port A behaviour is identical in both builds.

Test Plan:
- Clear after reset: release reset, hold all enables low.
  - busy=1 for exactly 64 cycles, then 0.
  - Read every address on port B: all return 0x00000000.
- Byte write on port A: write 0xAABBCCDD with a_be=4'b1111 to addr 5, then 0x11223344 with a_be=4'b0101 to addr 5.
  - Port A read of addr 5 returns 0xAA22CC44 one cycle after the read request.
  - a_dout=0 after each write cycle.
- Collision: mem[9]=0x12345678, then A writes 0xFFFFFFFF (be=1111) to addr 9 while B reads addr 9 in the same cycle.
  - b_dout=0x12345678 without the macro.
  - b_dout=0xFFFFFFFF with RAM_DP_WRITE_THROUGH_EN.
- clr in IDLE: fill addr 0..3 with nonzero data, pulse clr for 1 cycle.
  - busy rises on the next edge and stays high 64 cycles.
  - Port A write during busy is dropped.
  - After busy falls, addr 0..3 read 0.
- Mid-clear reset: assert reset at cycle 30 of a clear.
  - Outputs go to 0 immediately and busy stays 1.
  - After release, busy lasts a full 64 cycles.
  - clr pulses during the clear are ignored: busy length is unchanged.
- Enables low: a_cen=0, b_cen=0 with mem[0]=0xDEADBEEF.
  - Both douts read 0.
  - Raising b_cen with b_addr=0 gives 0xDEADBEEF after 1 cycle.
